// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the processor front end: word width, fetch states
// and the program-counter increment helper.
package fetch_sequencer_pkg;

    localparam int WORD_W       = 12;
    localparam int STROBE_CNT_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STROBE = 2'd2,
        ST_EXEC   = 2'd3
    } fetch_state_e;

    // 12-bit increment; 7777 octal wraps to 0000 through natural truncation.
    function automatic word_t pc_incr(input word_t pc_in);
        return pc_in + word_t'(1);
    endfunction

endpackage

// File: rtl/fetch_sequencer_strobe_timer.sv
// Strobe-width timer: after a start pulse, holds active high for len cycles.
// o_last flags the final active cycle so the sequencer can leave STROBE on time.
module strobe_timer
    import fetch_sequencer_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    start,
    input  logic [STROBE_CNT_W-1:0] len,
    output logic                    active,
    output logic                    o_last
);

    logic [STROBE_CNT_W-1:0] r_cnt;
    logic                    r_active;

    // Down-counter; active is registered so the strobe output comes straight from a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_cnt    <= len;
            r_active <= (len != '0);
        end else if (r_cnt > STROBE_CNT_W'(1)) begin
            r_cnt    <= r_cnt - STROBE_CNT_W'(1);
            r_active <= r_active;
        end else begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end
    end

    assign active = r_active;
    assign o_last = r_active && (r_cnt == STROBE_CNT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests the word at PC, registers it onto the
// instruction bus, strobes ckFetch for STROBE_LEN cycles, then waits for execute.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int STROBE_LEN = 2
) (
    input  logic              SYSCLK,
    input  logic              RESET,
    input  logic              run,
    input  logic              pcLoad,
    input  logic [WORD_W-1:0] pcLoadValue,
    output logic              memReq,
    output logic [WORD_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [WORD_W-1:0] memRdata,
    output logic [WORD_W-1:0] busData,
    output logic              ckFetch,
    input  logic              execDone,
    output logic [WORD_W-1:0] pc,
    output logic              busy
);

    localparam logic [STROBE_CNT_W-1:0] LEN_C = STROBE_CNT_W'(STROBE_LEN);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    word_t        r_pc;
    word_t        w_pc_next;
    word_t        r_mem_addr;
    word_t        r_bus_data;
    logic         r_mem_req;
    logic         r_busy;
    logic         w_bus_load;
    logic         w_tmr_start;
    logic         w_tmr_active;
    logic         w_tmr_last;

    // The first STROBE cycle (timer idle) launches the timer, giving busData
    // one full cycle of setup before ckFetch rises.
    assign w_tmr_start = (r_state == ST_STROBE) && !w_tmr_active;

    strobe_timer u_strobe_timer (
        .i_clk   (SYSCLK),
        .i_rst_n (RESET),
        .start   (w_tmr_start),
        .len     (LEN_C),
        .active  (w_tmr_active),
        .o_last  (w_tmr_last)
    );

    // Next-state, next-PC and bus-load decode.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_bus_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pcLoad) begin
                    w_pc_next = pcLoadValue;
                end else begin
                    w_pc_next = r_pc;
                end
                if (run) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (memAck) begin
                    w_bus_load   = 1'b1;
                    w_pc_next    = pc_incr(r_pc);
                    w_state_next = ST_STROBE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_STROBE: begin
                if (w_tmr_last) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_STROBE;
                end
            end
            ST_EXEC: begin
                if (pcLoad) begin
                    w_pc_next = pcLoadValue;
                end else begin
                    w_pc_next = r_pc;
                end
                if (execDone && run) begin
                    w_state_next = ST_REQ;
                end else if (execDone) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge SYSCLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Output registers are computed from the next state so they line up with it.
    always_ff @(posedge SYSCLK or negedge RESET) begin
        if (!RESET) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_mem_req  <= (w_state_next == ST_REQ);
            r_mem_addr <= w_pc_next;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    // Instruction bus holds the fetched word until the next acknowledge.
    always_ff @(posedge SYSCLK or negedge RESET) begin
        if (!RESET) begin
            r_bus_data <= '0;
        end else if (w_bus_load) begin
            r_bus_data <= memRdata;
        end else begin
            r_bus_data <= r_bus_data;
        end
    end

    assign memReq  = r_mem_req;
    assign memAddr = r_mem_addr;
    assign busData = r_bus_data;
    assign ckFetch = w_tmr_active;
    assign pc      = r_pc;
    assign busy    = r_busy;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a wait-state programmable memory responder.
module tb_fetch_sequencer;

    logic        SYSCLK;
    logic        RESET;
    logic        run;
    logic        pcLoad;
    logic [11:0] pcLoadValue;
    logic        memReq;
    logic [11:0] memAddr;
    logic        memAck;
    logic [11:0] memRdata;
    logic [11:0] busData;
    logic        ckFetch;
    logic        execDone;
    logic [11:0] pc;
    logic        busy;

    logic [11:0] mem [0:4095];
    int          n_wait;
    int          wait_cnt;
    int          n_chk;
    int          n_fail;

    fetch_sequencer #(.STROBE_LEN(2)) dut (
        .SYSCLK      (SYSCLK),
        .RESET       (RESET),
        .run         (run),
        .pcLoad      (pcLoad),
        .pcLoadValue (pcLoadValue),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memRdata    (memRdata),
        .busData     (busData),
        .ckFetch     (ckFetch),
        .execDone    (execDone),
        .pc          (pc),
        .busy        (busy)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Memory responder: acknowledges after n_wait request cycles.
    always begin
        @(posedge SYSCLK);
        #1;
        if (memReq) begin
            if (wait_cnt >= n_wait) begin
                memAck   = 1'b1;
                memRdata = mem[memAddr];
                wait_cnt = 0;
            end else begin
                memAck   = 1'b0;
                memRdata = 12'o7070;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            memAck   = 1'b0;
            memRdata = 12'o7070;
            wait_cnt = 0;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0o expected %0o", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic exec_pulse(input logic load, input logic [11:0] val);
        execDone    = 1'b1;
        pcLoad      = load;
        pcLoadValue = val;
        tick();
        execDone    = 1'b0;
        pcLoad      = 1'b0;
    endtask

    task automatic do_fetch(input int nwait, input logic [11:0] exp_addr,
                            input logic [11:0] exp_data, input logic strobe_load,
                            input logic drop_run);
        int          guard;
        int          lat;
        int          req_len;
        int          width;
        logic [11:0] exp_pc;
        exp_pc = exp_addr + 12'd1;
        guard  = 0;
        while (!memReq && guard < 20) begin
            tick();
            guard = guard + 1;
        end
        chk_val("req_seen", 32'(memReq), 32'd1);
        chk_val("req_addr", 32'(memAddr), 32'(exp_addr));
        if (drop_run) run = 1'b0;
        lat = 0;
        while (memReq && lat < 50) begin
            tick();
            lat = lat + 1;
        end
        req_len = lat;
        chk_val("req_len", 32'(req_len), 32'(nwait + 1));
        if (strobe_load) begin
            pcLoad      = 1'b1;
            pcLoadValue = 12'o5555;
        end
        while (!ckFetch && lat < 50) begin
            tick();
            pcLoad = 1'b0;
            lat    = lat + 1;
        end
        pcLoad = 1'b0;
        chk_val("ckf_latency", 32'(lat), 32'(nwait + 2));
        chk_val("bus_data", 32'(busData), 32'(exp_data));
        chk_val("pc_after", 32'(pc), 32'(exp_pc));
        width = 0;
        while (ckFetch && width < 20) begin
            tick();
            width = width + 1;
        end
        chk_val("ckf_width", 32'(width), 32'd2);
        chk_val("exec_busy", 32'(busy), 32'd1);
        chk_val("exec_noreq", 32'(memReq), 32'd0);
    endtask

    initial begin
        int guard;
        n_chk       = 0;
        n_fail      = 0;
        n_wait      = 0;
        wait_cnt    = 0;
        RESET       = 1'b0;
        run         = 1'b0;
        pcLoad      = 1'b0;
        pcLoadValue = 12'o0000;
        execDone    = 1'b0;
        memAck      = 1'b0;
        memRdata    = 12'o0000;
        for (int i = 0; i < 4096; i++) mem[i] = 12'o0000;
        mem[12'o0000] = 12'o7200;
        mem[12'o0001] = 12'o4321;
        mem[12'o0200] = 12'o2222;
        mem[12'o0300] = 12'o3030;
        mem[12'o7777] = 12'o1111;

        repeat (3) tick();
        chk_val("rst_memreq", 32'(memReq), 32'd0);
        chk_val("rst_pc", 32'(pc), 32'd0);
        chk_val("rst_busdata", 32'(busData), 32'd0);
        chk_val("rst_ckfetch", 32'(ckFetch), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_memaddr", 32'(memAddr), 32'd0);

        RESET = 1'b1;
        run   = 1'b1;
        do_fetch(0, 12'o0000, 12'o7200, 1'b0, 1'b0);

        n_wait = 3;
        exec_pulse(1'b0, 12'o0000);
        do_fetch(3, 12'o0001, 12'o4321, 1'b1, 1'b0);

        n_wait = 0;
        exec_pulse(1'b1, 12'o0200);
        do_fetch(0, 12'o0200, 12'o2222, 1'b0, 1'b0);

        exec_pulse(1'b1, 12'o7777);
        do_fetch(0, 12'o7777, 12'o1111, 1'b0, 1'b0);
        exec_pulse(1'b0, 12'o0000);
        do_fetch(0, 12'o0000, 12'o7200, 1'b0, 1'b0);

        n_wait = 2;
        exec_pulse(1'b0, 12'o0000);
        do_fetch(2, 12'o0001, 12'o4321, 1'b0, 1'b1);
        exec_pulse(1'b0, 12'o0000);
        chk_val("stop_busy", 32'(busy), 32'd0);
        chk_val("stop_memreq", 32'(memReq), 32'd0);
        tick();
        chk_val("idle_hold", 32'(busy), 32'd0);

        execDone = 1'b1;
        tick();
        execDone = 1'b0;
        tick();
        chk_val("idle_execdone", 32'(busy), 32'd0);
        pcLoad      = 1'b1;
        pcLoadValue = 12'o0300;
        tick();
        pcLoad = 1'b0;
        chk_val("idle_pcload", 32'(pc), 32'o0300);
        chk_val("idle_memaddr", 32'(memAddr), 32'o0300);

        n_wait = 0;
        run    = 1'b1;
        guard  = 0;
        while (!memReq && guard < 20) begin
            tick();
            guard = guard + 1;
        end
        chk_val("pre_rst_addr", 32'(memAddr), 32'o0300);
        tick();
        tick();
        chk_val("pre_rst_ckf", 32'(ckFetch), 32'd1);
        chk_val("pre_rst_bus", 32'(busData), 32'o3030);
        #3;
        RESET = 1'b0;
        #1;
        chk_val("mid_rst_ckf", 32'(ckFetch), 32'd0);
        chk_val("mid_rst_req", 32'(memReq), 32'd0);
        chk_val("mid_rst_pc", 32'(pc), 32'd0);
        chk_val("mid_rst_busy", 32'(busy), 32'd0);
        chk_val("mid_rst_bus", 32'(busData), 32'd0);
        tick();
        chk_val("rst_held_busy", 32'(busy), 32'd0);
        RESET = 1'b1;
        do_fetch(0, 12'o0000, 12'o7200, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
